// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Handshake: a start sampled high in IDLE or DONE is accepted; done pulses one cycle with result valid.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        a_neg_q, a_neg_d;
    logic        res_neg_q, res_neg_d;
    logic [63:0] prod_q, prod_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic        div_zero, div_ovf;
    logic [31:0] fast_res;
    logic [32:0] mul_sum;
    logic [33:0] div_shift, div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_res;

    assign is_div_in   = funct3[2];
    assign a_signed_in = is_div_in ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    assign b_signed_in = is_div_in ? ~funct3[0] : (funct3 == 3'b001);
    assign a_neg_in    = a_signed_in & operand_a[31];
    assign b_neg_in    = b_signed_in & operand_b[31];
    assign a_mag_in    = a_neg_in ? (32'd0 - operand_a) : operand_a;
    assign b_mag_in    = b_neg_in ? (32'd0 - operand_b) : operand_b;

    // Divide corner cases bypass the iteration and complete one cycle after accept.
    assign div_zero = is_div_in && (operand_b == 32'd0);
    assign div_ovf  = is_div_in && !funct3[0] && (operand_a == 32'h8000_0000)
                      && (operand_b == 32'hFFFF_FFFF);
    assign fast_res = div_zero ? (funct3[1] ? operand_a : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'd0 : 32'h8000_0000);

    assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_mag_q} : 33'd0);
    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift - {2'b00, b_mag_q};

    assign prod_fix = res_neg_q ? (64'd0 - prod_q) : prod_q;
    assign quo_fix  = res_neg_q ? (32'd0 - quo_q) : quo_q;
    assign rem_fix  = a_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q == 3'b000) ? prod_fix[31:0] : prod_fix[63:32]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        a_neg_d   = a_neg_q;
        res_neg_d = res_neg_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d      = funct3;
                    a_mag_d   = a_mag_in;
                    b_mag_d   = b_mag_in;
                    a_neg_d   = a_neg_in;
                    res_neg_d = a_neg_in ^ b_neg_in;
                    cnt_d     = 5'd0;
                    prod_d    = {32'd0, b_mag_in};
                    rem_d     = 33'd0;
                    quo_d     = a_mag_in;
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    // Quotient bits enter at the bottom as dividend bits leave the top.
                    if (!div_diff[33]) begin
                        rem_d = div_diff[32:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = div_shift[32:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end else begin
                    prod_d = {mul_sum, prod_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            default: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            a_mag_q   <= 32'd0;
            b_mag_q   <= 32'd0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            prod_q    <= 64'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            a_neg_q   <= a_neg_d;
            res_neg_q <= res_neg_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule
